// File: rtl/sdn_match_pkg.sv
// Shared definitions for the SDN match pipeline: rule-count defaults, derived
// field widths, collector state encoding and the per-packet result record
// handed to the action stage.
package sdn_match_pkg;

   // Rules evaluated per packet (also the maximum beats per packet).
   localparam int NUM_RULES_DEF = 4;

   // Rule index width: enough to address every rule (2**IDX_W >= NUM_RULES).
   localparam int IDX_W_DEF = (NUM_RULES_DEF > 1) ? $clog2(NUM_RULES_DEF) : 1;

   // Hit count width: must hold the value NUM_RULES itself (2**CNT_W > NUM_RULES).
   localparam int CNT_W_DEF = $clog2(NUM_RULES_DEF + 1);

   // Collector states. COLLECT accepts compare beats; HOLD presents a result.
   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } collect_state_t;

   // Per-packet result as seen by the action stage.
   typedef struct packed {
      logic                 hit;
      logic [IDX_W_DEF-1:0] idx;
      logic [CNT_W_DEF-1:0] count;
      logic                 err;
   } match_result_t;

   // Saturating increment of the hit counter.
   function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
      if (v == {CNT_W_DEF{1'b1}}) begin
         return v;
      end
      return v + 1'b1;
   endfunction

endpackage

// File: rtl/match_result_collector.sv
// Consumer end of the chained-comparator path. Collects one compare hit per
// rule per beat, resolves the packet into first-match index plus hit count,
// and holds the result for the action stage until it is taken.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The producer keeps valid and its payload stable until that edge. On the
// input side in_ready depends on state only; on the output side out_valid and
// all out_* fields are stable while out_valid=1 and out_ready=0.
module match_result_collector
   import sdn_match_pkg::*;
#(
   parameter int NUM_RULES = NUM_RULES_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_hit,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err
);

   localparam logic [IDX_W-1:0] LAST_RULE = IDX_W'(NUM_RULES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   collect_state_t   state, state_nxt;

   // Accumulators for the packet currently being collected.
   logic [IDX_W-1:0] rule_cnt;
   logic             acc_hit;
   logic [IDX_W-1:0] acc_idx;
   logic [CNT_W-1:0] acc_cnt;

   // Values the accumulators take once the current beat is folded in.
   logic             beat_acc;
   logic             pkt_end;
   logic             pkt_forced;
   logic             nxt_hit;
   logic [IDX_W-1:0] nxt_idx;
   logic [CNT_W-1:0] nxt_cnt;
   logic             out_take;

   // Fold the current beat into the running first-hit / count values.
   always_comb begin
      beat_acc   = in_valid && in_ready;
      out_take   = out_valid && out_ready;
      pkt_forced = !in_last && (rule_cnt == LAST_RULE);
      pkt_end    = beat_acc && (in_last || (rule_cnt == LAST_RULE));
      nxt_hit    = acc_hit || in_hit;
      nxt_idx    = acc_idx;
      if (!acc_hit && in_hit) begin
         nxt_idx = rule_cnt;
      end
      nxt_cnt = acc_cnt;
      if (in_hit && (acc_cnt != CNT_MAX)) begin
         nxt_cnt = acc_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and input-side ready.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      unique case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (pkt_end) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_take) begin
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Per-beat accumulation; everything clears at packet end.
   always_ff @(posedge clk) begin
      if (rst) begin
         rule_cnt <= '0;
         acc_hit  <= 1'b0;
         acc_idx  <= '0;
         acc_cnt  <= '0;
      end else if (pkt_end) begin
         rule_cnt <= '0;
         acc_hit  <= 1'b0;
         acc_idx  <= '0;
         acc_cnt  <= '0;
      end else if (beat_acc) begin
         rule_cnt <= rule_cnt + 1'b1;
         acc_hit  <= nxt_hit;
         acc_idx  <= nxt_idx;
         acc_cnt  <= nxt_cnt;
      end
   end

   // Result register: loaded at packet end, held until the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_idx   <= '0;
         out_count <= '0;
         out_err   <= 1'b0;
      end else if (pkt_end) begin
         out_valid <= 1'b1;
         out_hit   <= nxt_hit;
         out_idx   <= nxt_idx;
         out_count <= nxt_cnt;
         out_err   <= pkt_forced;
      end else if (out_take) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/match_result_collector.md
Name: match_result_collector

Overview:
- Consumer end of the chained-comparator path: accepts the per-rule compare result stream (one 1-bit hit per rule per beat, rule order) that the comparator produces for each packet key.
- Resolves each packet into a first-match rule index plus a hit count, and hands the result to the action stage over a valid/ready handshake.
- Sits between the chained_comp instances and the downstream action/forwarding logic in the SDN match pipeline.

Parameters:
- NUM_RULES, 4, rules evaluated per packet; the maximum number of beats per packet.
- IDX_W, 2, rule index width; must satisfy 2**IDX_W >= NUM_RULES.
- CNT_W, 3, hit count width; must satisfy 2**CNT_W > NUM_RULES.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  compare beat present.
- in_hit  in  1  compare result for the current rule (1 = match).
- in_last  in  1  final rule beat of this packet.
- in_ready  out  1  collector can accept a beat.
- out_valid  out  1  packet result pending.
- out_ready  in  1  downstream accepts the result.
- out_hit  out  1  at least one rule matched.
- out_idx  out  IDX_W  lowest-numbered matching rule; 0 when out_hit=0.
- out_count  out  CNT_W  number of matching rules.
- out_err  out  1  packet was force-terminated (see Behaviour).

Behaviour:
- Reset (rst=1 at a clock edge): state=COLLECT, rule_cnt=0, the accumulators are cleared, out_valid=0, out_hit=0, out_idx=0, out_count=0, out_err=0. A reset mid-packet or mid-HOLD discards all partial and pending results. in_ready reads 1 in the first cycle after reset.
- in_ready = (state==COLLECT). It is combinational from state only and never depends on out_ready; there is no bypass.
- A beat is accepted when in_valid && in_ready. In COLLECT with in_valid=0, nothing changes.
- Per accepted beat:
  - If in_hit=1 and no hit has been recorded yet, record rule_cnt as the first-match index.
  - If in_hit=1, increment hit_cnt (saturating at 2**CNT_W-1, which is unreachable under the parameter constraints).
  - Increment rule_cnt.
- Packet end is the accepted beat with in_last=1, OR the accepted beat with rule_cnt==NUM_RULES-1 and in_last=0.
  - The second case is forced termination and sets out_err=1 for that result.
  - Beats that follow a forced termination start a new packet. No resync is attempted.
- On packet end (same edge):
  - The outputs are loaded from the accumulators, including the current beat.
  - out_valid goes to 1 and state goes to HOLD.
  - rule_cnt, hit_cnt and the first-hit accumulators are cleared.
  - Latency: the result is visible in the cycle after the last beat is accepted.
- HOLD:
  - out_* stay stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid goes to 0 and state returns to COLLECT, so in_ready=1 in the next cycle.
  - The other out_* fields keep their last values after handshake. They are don't-care when out_valid=0.
- Throughput: at most one packet every NUM_RULES+1 cycles.
- A packet of one beat (in_last on rule 0) is legal. For it, out_count is 0 or 1 and out_idx is 0.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package sdn_match_pkg holds:
  - the NUM_RULES default;
  - the IDX_W and CNT_W derivations;
  - the state encoding COLLECT=1'b0, HOLD=1'b1;
  - a result struct {hit, idx, count, err}, shared with the action stage.
- No sub-module is needed. The first-hit/count accumulator stays inline, since a single always block covers it.

Test Plan:
- Reset, then the beats hit=0,1,0,1 with last on beat 3 and out_ready=1 → one cycle later out_valid=1, out_hit=1, out_idx=1, out_count=2, out_err=0. in_ready is 0 for exactly one cycle.
- Four beats, all hit=0, last on beat 3 → out_hit=0, out_idx=0, out_count=0.
- Beats 1,1,1,1 with out_ready held 0 for 5 cycles → out_valid, out_idx=0 and out_count=4 stay stable, in_ready=0 throughout. After out_ready=1 for one cycle, in_ready=1 on the following cycle.
- Four beats with in_last=0 (hit=0,0,1,0), then two more beats hit=1 with last on the second → first result: out_err=1, out_idx=2, out_count=1. Second result: out_err=0, out_idx=0, out_count=2.
- Single beat, hit=1, last=1 → out_idx=0, out_count=1. A back-to-back packet is accepted starting 2 cycles after the first beat.
- Assert rst after beat 2 (hits 1,1) → out_valid=0. A following packet 0,0,0,1(last) yields out_idx=3, out_count=1, with no carry-over from before the reset.
